// File: rtl/cla_seq_pkg.sv
// Shared types and sizing for the multi-precision CLA add/subtract sequencer.
package cla_seq_pkg;

  localparam int WORD_W    = 256;
  localparam int MAX_WORDS = 16;

  // Width of a field that counts 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int CNT_W = cnt_width(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} seq_state_t;

endpackage

// File: rtl/cla_256bit.sv
// 256-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
module cla_256bit (
  input  logic [255:0] din1,
  input  logic [255:0] din2,
  input  logic         cin,
  output logic [255:0] dout,
  output logic         cout,
  output logic         pg,
  output logic         gg
);

  logic [255:0] g;
  logic [255:0] p;
  logic [63:0]  grp_g;
  logic [63:0]  grp_p;

  assign g = din1 & din2;
  assign p = din1 ^ din2;

  always_comb begin
    for (int k = 0; k < 64; k++) begin
      grp_p[k] = &p[k*4 +: 4];
      grp_g[k] = g[k*4+3] | (p[k*4+3] & g[k*4+2]) | (p[k*4+3] & p[k*4+2] & g[k*4+1]) |
                 (p[k*4+3] & p[k*4+2] & p[k*4+1] & g[k*4]);
    end
  end

  always_comb begin
    logic cg;
    logic c1;
    logic c2;
    logic c3;
    logic gacc;
    cg   = cin;
    gacc = 1'b0;
    dout = '0;
    for (int k = 0; k < 64; k++) begin
      c1 = g[k*4] | (p[k*4] & cg);
      c2 = g[k*4+1] | (p[k*4+1] & g[k*4]) | (p[k*4+1] & p[k*4] & cg);
      c3 = g[k*4+2] | (p[k*4+2] & g[k*4+1]) | (p[k*4+2] & p[k*4+1] & g[k*4]) |
           (p[k*4+2] & p[k*4+1] & p[k*4] & cg);
      dout[k*4 +: 4] = p[k*4 +: 4] ^ {c3, c2, c1, cg};
      cg   = grp_g[k] | (grp_p[k] & cg);
      gacc = grp_g[k] | (grp_p[k] & gacc);
    end
    cout = cg;
    gg   = gacc;
  end

  assign pg = &grp_p;

endmodule

// File: rtl/cla_mp_add_seq.sv
// Multi-precision add/subtract sequencer: streams LS-first word pairs through one
// shared 256-bit CLA, chaining the registered carry from word to word.
module cla_mp_add_seq
  import cla_seq_pkg::*;
#(
  parameter int WORD_W    = cla_seq_pkg::WORD_W,  // must stay 256 to match cla_256bit
  parameter int MAX_WORDS = cla_seq_pkg::MAX_WORDS,
  parameter int CNT_W     = cla_seq_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CNT_W-1:0]  cmd_nwords,
  input  logic              cmd_sub,
  input  logic              cmd_cin,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [WORD_W-1:0] op_a,
  input  logic [WORD_W-1:0] op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WORD_W-1:0] res_data,
  output logic              res_last,
  output logic              res_cout,
  output logic              res_ovf,
  output logic              res_zero,
  output logic              busy,
  output seq_state_t        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; a producer holds valid and its payload stable until that edge.

  seq_state_t        state;
  seq_state_t        state_nx;
  logic              sub_q;
  logic              carry_q;
  logic              zero_acc;
  logic [CNT_W-1:0]  remain;
  logic [WORD_W-1:0] din2;
  logic [WORD_W-1:0] dout;
  logic              cout;
  logic              cmd_fire;
  logic              op_fire;
  logic              last_word;
  logic              dout_zero;

  assign din2 = sub_q ? ~op_b : op_b;

  cla_256bit u_cla (
    .din1 (op_a),
    .din2 (din2),
    .cin  (carry_q),
    .dout (dout),
    .cout (cout),
    .pg   (),
    .gg   ()
  );

  assign cmd_ready = (state == IDLE);
  assign op_ready  = (state == RUN) && (!res_valid || res_ready);
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign op_fire   = op_valid && op_ready;
  assign last_word = (remain == '0);
  assign dout_zero = (dout == '0);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_valid) state_nx = RUN;
      RUN:     if (op_fire && last_word) state_nx = DRAIN;
      DRAIN:   if (res_valid && res_ready && res_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      zero_acc  <= 1'b1;
      remain    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_last  <= 1'b0;
      res_cout  <= 1'b0;
      res_ovf   <= 1'b0;
      res_zero  <= 1'b0;
    end else begin
      state <= state_nx;
      if (cmd_fire) begin
        sub_q    <= cmd_sub;
        remain   <= cmd_nwords;
        carry_q  <= cmd_sub ? ~cmd_cin : cmd_cin;
        zero_acc <= 1'b1;
      end
      if (op_fire) begin
        res_data  <= dout;
        res_valid <= 1'b1;
        carry_q   <= cout;
        zero_acc  <= zero_acc & dout_zero;
        if (!last_word) remain <= remain - 1'b1;
        res_last  <= last_word;
        // Subtraction runs as A + ~B + ~borrow, so the raw carry is an inverted borrow.
        res_cout  <= last_word & (sub_q ? ~cout : cout);
        res_ovf   <= last_word & (op_a[WORD_W-1] == din2[WORD_W-1]) &
                     (dout[WORD_W-1] != op_a[WORD_W-1]);
        res_zero  <= last_word & zero_acc & dout_zero;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cla_mp_add_seq.md
Name: cla_mp_add_seq

Overview:
- Multi-precision add/subtract sequencer around a single cla_256bit instance.
- Accepts one command (word count, add/sub, carry/borrow-in), then streams 256-bit operand word pairs LS-word first.
- Each word pair goes through the shared adder; the word carry is registered and chained into the next word.
- Emits result words with last/carry/overflow/zero flags; sits between a big-integer arithmetic front end and its result sink.

Parameters:
- WORD_W, 256, adder word width; fixed to cla_256bit width, other values illegal.
- MAX_WORDS, 16, maximum words per operation.
- CNT_W, 4, width of word-count field; clog2(MAX_WORDS).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_nwords  in  CNT_W  number of words minus 1 (0 = 1 word).
- cmd_sub  in  1  0 = A+B, 1 = A-B.
- cmd_cin  in  1  carry-in (add) or borrow-in (sub) for word 0.
- op_valid  in  1  operand word pair present.
- op_ready  out  1  operand word pair accepted this cycle when op_valid also high.
- op_a  in  WORD_W  operand A word.
- op_b  in  WORD_W  operand B word.
- res_valid  out  1  result word present.
- res_ready  in  1  sink accepts result.
- res_data  out  WORD_W  result word.
- res_last  out  1  final word of the operation.
- res_cout  out  1  on last word: carry-out (add) or borrow-out (sub); 0 otherwise.
- res_ovf  out  1  on last word: signed two's-complement overflow; 0 otherwise.
- res_zero  out  1  on last word: every result word of the operation was zero; 0 otherwise.
- busy  out  1  state != IDLE.

Behaviour:
- States:
  - IDLE: cmd_ready=1.
  - RUN: accepting operands.
  - DRAIN: last word accepted, waiting for its result to be taken.
- Transitions:
  - IDLE -> RUN on cmd_valid. This latches cmd_sub, remain=cmd_nwords, and carry_q = cmd_sub ? ~cmd_cin : cmd_cin.
  - RUN -> DRAIN when the word with remain==0 is accepted.
  - DRAIN -> IDLE when res_valid && res_ready && res_last.
  - cmd_ready is 0 outside IDLE.
- Adder connections:
  - din1=op_a.
  - din2 = cmd_sub ? ~op_b : op_b.
  - cin=carry_q.
  - The adder is purely combinational.
- Single output register, 1-cycle latency.
- op_ready = (state==RUN) && (!res_valid || res_ready). This gives full throughput of 1 word/cycle under no backpressure.
- On operand accept:
  - res_data <= dout.
  - res_valid <= 1.
  - carry_q <= cout.
  - remain decrements.
  - zero_acc <= zero_acc & (dout==0). zero_acc is set to 1 at command accept.
- On last word:
  - res_last=1.
  - res_cout = cmd_sub ? ~cout : cout.
  - res_ovf = (op_a[255]==din2[255]) && (dout[255]!=op_a[255]).
  - res_zero = zero_acc & (dout==0).
- Non-last words: res_last, res_cout, res_ovf and res_zero are 0.
- res_valid clears on res_ready when no new word is accepted the same cycle. Simultaneous accept and drain keeps res_valid=1 and loads the new word.
- Output hold: res_* stays stable while res_valid && !res_ready.
- op_* is ignored outside RUN. cmd_* is ignored outside IDLE.
- Reset (any time, including mid-operation):
  - state=IDLE, res_valid=0, all res_* flags 0, res_data=0.
  - carry_q=0, remain=0, zero_acc=1, cmd_ready=1, op_ready=0, busy=0.
  - A partial operation is discarded; nothing is emitted after reset.
- Wrap-around: remain never underflows; the transition happens on 0.
- cmd_nwords is full range: nwords field max gives MAX_WORDS words.

Decomposition:
- Package cla_seq_pkg holds:
  - localparam WORD_W=256.
  - typedef enum logic [1:0] {IDLE, RUN, DRAIN} seq_state_t.
  - The CNT_W helper.
- One sub-module: the existing cla_256bit instance, used unmodified. Its pg/gg outputs are left unconnected.
- All control stays in this module.

Test Plan:
- 1-word add:
  - Stimulus: nwords=0, A=5, B=7, cin=0.
  - Response: one result 12, last=1, cout=0, ovf=0, zero=0, 1 cycle after accept.
- 4-word carry ripple:
  - Stimulus: A words all 2^256-1, B = {0,0,0,1}, no backpressure.
  - Response: four zero words back-to-back, last on word 4, cout=1, zero=1.
- Subtract with borrow:
  - Stimulus: nwords=1, sub=1, A={0,0}, B={0,1}.
  - Response: both words all-ones, cout (borrow)=1, ovf=0.
- Signed overflow:
  - Stimulus: 1 word, A=2^255-1, B=1, add.
  - Response: result 2^255, ovf=1, cout=0.
- Backpressure:
  - Stimulus: 3-word op with res_ready held low 5 cycles after the first result.
  - Response: op_ready=0 while stalled, res_data held stable, no word lost or duplicated, results match the golden model.
- Reset mid-op:
  - Stimulus: assert rst after word 2 of 4.
  - Response: res_valid=0, busy=0, cmd_ready=1 immediately. A following 1-word add 1+1 returns 2 with clean flags.
